xh_cdb_link_tx: RTL and testbench
=================================

XH_CDB_LINK_TX -- requirements
Module: xh_cdb_link_tx

Interface
REQ-001 Parameters (name, default, meaning): FLIT_W, 392, flit width; DEPTH, 4, FIFO entries (power of two, at least 2); MAX_CRD, 15, maximum L-credits held.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset; deassertion is synchronised externally.
REQ-004 in_valid  in  1  upstream flit valid.
REQ-005 in_ready  out  1  FIFO can accept a flit.
REQ-006 in_flit  in  FLIT_W  upstream flit payload.
REQ-007 link_en  in  1  request from power control to bring the link up (1) or down (0).
REQ-008 txlinkactivereq  out  1  link activation request to the downstream CDB device.
REQ-009 txlinkactiveack  in  1  link activation acknowledge from the downstream CDB device.
REQ-010 tx_flitpend  out  1  early flit indication.
REQ-011 tx_flitv  out  1  flit valid; consumes one credit.
REQ-012 tx_flit  out  FLIT_W  registered flit payload.
REQ-013 tx_lcrdv  in  1  one L-credit granted per cycle asserted.
REQ-014 crd_ovf  out  1  sticky error flag: credit received while credit count = MAX_CRD.
REQ-015 link_state  out  2  current FSM state: STOP=0, ACT=1, RUN=2, DEACT=3.

Function
REQ-016 The FSM SHALL implement these states and outputs: STOP (req=0, expecting ack=0), ACT (req=1, waiting for ack=1), RUN (req=1, ack=1), DEACT (req=0, waiting for ack=0).
REQ-017 The FSM SHALL make these transitions: STOP->ACT when link_en=1 and ack=0; ACT->RUN when ack=1; RUN->DEACT when link_en=0; DEACT->STOP when ack=0 and credit count=0; all other cases hold state.
REQ-018 txlinkactivereq SHALL be registered and asserted exactly in ACT and RUN.
REQ-019 The credit counter SHALL be ceil(log2(MAX_CRD+1)) bits wide.
REQ-020 The credit counter SHALL increment on tx_lcrdv in ACT, RUN and DEACT, and SHALL ignore tx_lcrdv in STOP.
REQ-021 The credit counter SHALL saturate at MAX_CRD; a tx_lcrdv at MAX_CRD SHALL set crd_ovf, which stays set until reset.
REQ-022 If a credit arrives and a flit is sent in the same cycle, the count SHALL be unchanged.
REQ-023 In RUN, when the FIFO is non-empty and credit count > 0, the block SHALL pop the FIFO head and drive it on the next cycle with tx_flitv=1; one flit per cycle maximum.
REQ-024 In DEACT, when credit count > 0, the block SHALL send one credit-return flit per cycle (tx_flitv=1, tx_flit all zero) until credit count = 0; the FIFO SHALL NOT drain in DEACT.
REQ-025 tx_flitv SHALL NOT assert in STOP or ACT, nor with credit count = 0.
REQ-026 FIFO: in_ready = not full; a push occurs on in_valid and in_ready.
REQ-027 FIFO simultaneous push and pop when full SHALL be disallowed, because in_ready=0 while full; push and pop when empty SHALL NOT bypass the FIFO.
REQ-028 Minimum latency from in_valid&in_ready at cycle N to tx_flitv SHALL be cycle N+2: the flit is written at N+1 and the registered output asserts at N+2.
REQ-029 FIFO read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be decoded from an extra pointer wrap bit.
REQ-030 tx_flit SHALL hold its last value while tx_flitv=0.

Reset
REQ-031 Reset SHALL force: state=STOP, credits=0, FIFO empty, txlinkactivereq=0, tx_flitv=0, tx_flitpend=0, tx_flit=0, crd_ovf=0, in_ready=0 during reset and 1 after.
REQ-032 Reset asserted mid-operation SHALL discard FIFO contents and held credits without emitting return flits.

Configuration
REQ-033 Macro XH_CDB_LINK_TX_FLITPEND_EN defined: tx_flitpend SHALL be registered and asserted the cycle before any tx_flitv, i.e. when RUN with FIFO non-empty or in_valid, or DEACT with credits > 0.
REQ-034 Macro XH_CDB_LINK_TX_FLITPEND_EN undefined: tx_flitpend SHALL be 1 in every state except STOP; flit timing SHALL be identical in both builds.

Verification
REQ-035 Bring-up: link_en=1, ack returned 2 cycles after req -> link_state sequence 0,1,2; txlinkactivereq=1 from the cycle after link_en.
REQ-036 Credit gating: RUN, 3 flits pushed, 0 credits -> no tx_flitv; then 2 tx_lcrdv pulses -> exactly 2 flits out in order, credits=0, third flit stays queued.
REQ-037 Back-pressure: DEPTH=4, no credits, 5 pushes attempted -> in_ready=0 after the 4th push; the 5th is accepted only after the first flit is sent.
REQ-038 Deactivation: RUN with 3 credits and empty FIFO, link_en=0 -> 3 all-zero return flits on consecutive cycles, then STOP once ack=0.
REQ-039 Overflow and simultaneity: 15 credits plus one more tx_lcrdv -> crd_ovf=1 and count=15; tx_lcrdv together with a send at count 5 -> count stays 5.
REQ-040 Mid-operation reset: rst_n asserted while RUN with 2 queued flits -> all outputs reach reset values immediately, with no tx_flitv after release.

Source files
------------

// File: rtl/xh_cdb_link_tx.sv
// rtl/xh_cdb_link_tx.sv - CDB link transmitter: activation FSM, flit FIFO and L-credit accounting.
// Optional feature macro: XH_CDB_LINK_TX_FLITPEND_EN (predictive registered tx_flitpend).
module xh_cdb_link_tx #(
    parameter int FLIT_W  = 392,
    parameter int DEPTH   = 4,
    parameter int MAX_CRD = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              link_en,
    output logic              txlinkactivereq,
    input  logic              txlinkactiveack,
    output logic              tx_flitpend,
    output logic              tx_flitv,
    output logic [FLIT_W-1:0] tx_flit,
    input  logic              tx_lcrdv,
    output logic              crd_ovf,
    output logic [1:0]        link_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_CRD + 1);
    localparam logic [CW-1:0] CRD_MAX = CW'(MAX_CRD);
    localparam logic [CW-1:0] CRD_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_ACT   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DEACT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     crd;
    logic [CW-1:0]     crd_nx;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              ret;
    logic              send;
    logic              crd_inc;
    logic              pend_nx;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = rst_n & ~fifo_full;
    assign push       = in_valid & in_ready;

    assign pop     = (state == ST_RUN) && !fifo_empty && (crd != '0);
    assign ret     = (state == ST_DEACT) && (crd != '0);
    assign send    = pop | ret;
    assign crd_inc = tx_lcrdv && (state != ST_STOP);

    always_comb begin
        state_nx = state;
        case (state)
            ST_STOP:  if (link_en && !txlinkactiveack) state_nx = ST_ACT;
            ST_ACT:   if (txlinkactiveack) state_nx = ST_RUN;
            ST_RUN:   if (!link_en) state_nx = ST_DEACT;
            ST_DEACT: if (!txlinkactiveack && (crd == '0)) state_nx = ST_STOP;
        endcase
    end

    // A credit arriving in the same cycle as a send cancels out.
    always_comb begin
        crd_nx = crd;
        if (crd_inc && !send) begin
            if (crd != CRD_MAX) crd_nx = crd + CRD_ONE;
        end else if (send && !crd_inc) begin
            crd_nx = crd - CRD_ONE;
        end
    end

`ifdef XH_CDB_LINK_TX_FLITPEND_EN
    logic fifo_empty_nx;
    assign fifo_empty_nx = ((wr_ptr + PW'(push)) == (rd_ptr + PW'(pop)));
    assign pend_nx = ((state_nx == ST_RUN) && (!fifo_empty_nx || in_valid)) ||
                     ((state_nx == ST_DEACT) && (crd_nx != '0));
`else
    assign pend_nx = (state_nx != ST_STOP);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_STOP;
            crd             <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            txlinkactivereq <= 1'b0;
            tx_flitpend     <= 1'b0;
            tx_flitv        <= 1'b0;
            tx_flit         <= '0;
            crd_ovf         <= 1'b0;
        end else begin
            state           <= state_nx;
            crd             <= crd_nx;
            txlinkactivereq <= (state_nx == ST_ACT) || (state_nx == ST_RUN);
            tx_flitpend     <= pend_nx;
            tx_flitv        <= send;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            // Return flits carry an all-zero payload; otherwise the last flit is held.
            if (pop) tx_flit <= mem[rd_ptr[AW-1:0]];
            else if (ret) tx_flit <= '0;
            if (crd_inc && (crd == CRD_MAX)) crd_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_flit;
    end

    assign link_state = state;
endmodule

// File: tb/tb_xh_cdb_link_tx.sv
// tb/tb_xh_cdb_link_tx.sv - self-checking bench for xh_cdb_link_tx with a queue-based reference model.
module tb_xh_cdb_link_tx;
    localparam int FLIT_W  = 392;
    localparam int DEPTH   = 4;
    localparam int MAX_CRD = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] in_flit;
    logic              link_en;
    logic              txlinkactivereq;
    logic              txlinkactiveack;
    logic              tx_flitpend;
    logic              tx_flitv;
    logic [FLIT_W-1:0] tx_flit;
    logic              tx_lcrdv;
    logic              crd_ovf;
    logic [1:0]        link_state;

    always #5 clk = ~clk;

    xh_cdb_link_tx #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .MAX_CRD(MAX_CRD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .link_en(link_en), .txlinkactivereq(txlinkactivereq), .txlinkactiveack(txlinkactiveack),
        .tx_flitpend(tx_flitpend), .tx_flitv(tx_flitv), .tx_flit(tx_flit), .tx_lcrdv(tx_lcrdv),
        .crd_ovf(crd_ovf), .link_state(link_state)
    );

    int total = 0;
    int bad   = 0;

    int                m_state;
    int                m_crd;
    logic [FLIT_W-1:0] m_q[$];
    bit                m_ovf, m_flitv, m_req, m_pend;
    logic [FLIT_W-1:0] m_flit;

    task automatic chk(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] rand_flit();
        logic [FLIT_W-1:0] f;
        f = '0;
        for (int i = 0; i < (FLIT_W + 31) / 32; i++) f = {f[FLIT_W-33:0], 32'($urandom)};
        return f;
    endfunction

    task automatic model_reset();
        m_state = 0; m_crd = 0; m_q.delete();
        m_ovf = 0; m_flitv = 0; m_req = 0; m_pend = 0; m_flit = '0;
    endtask

    // Cycle behaviour stated in terms of a flit queue and an integer credit pool.
    task automatic model_edge(input bit le, input bit ack, input bit lc, input bit iv,
                              input logic [FLIT_W-1:0] f);
        bit push, inc, pop, ret;
        int crd_pre, nst;
        crd_pre = m_crd;
        push = iv && (m_q.size() < DEPTH);
        inc  = lc && (m_state != 0);
        pop  = (m_state == 2) && (m_q.size() != 0) && (m_crd > 0);
        ret  = (m_state == 3) && (m_crd > 0);
        if (inc && m_crd == MAX_CRD) m_ovf = 1;
        m_flitv = pop || ret;
        if (pop) m_flit = m_q.pop_front();
        else if (ret) m_flit = '0;
        if (push) m_q.push_back(f);
        m_crd = m_crd + int'(inc) - int'(pop || ret);
        if (m_crd > MAX_CRD) m_crd = MAX_CRD;
        nst = m_state;
        case (m_state)
            0: if (le && !ack) nst = 1;
            1: if (ack) nst = 2;
            2: if (!le) nst = 3;
            default: if (!ack && crd_pre == 0) nst = 0;
        endcase
        m_state = nst;
        m_req = (nst == 1) || (nst == 2);
`ifdef XH_CDB_LINK_TX_FLITPEND_EN
        m_pend = ((nst == 2) && (m_q.size() != 0 || iv)) || ((nst == 3) && m_crd > 0);
`else
        m_pend = (nst != 0);
`endif
    endtask

    task automatic check_all();
        chk("state", FLIT_W'(link_state), FLIT_W'(m_state));
        chk("req", FLIT_W'(txlinkactivereq), FLIT_W'(m_req));
        chk("flitpend", FLIT_W'(tx_flitpend), FLIT_W'(m_pend));
        chk("flitv", FLIT_W'(tx_flitv), FLIT_W'(m_flitv));
        chk("flit", tx_flit, m_flit);
        chk("ovf", FLIT_W'(crd_ovf), FLIT_W'(m_ovf));
        chk("in_ready", FLIT_W'(in_ready), FLIT_W'(rst_n && (m_q.size() < DEPTH)));
    endtask

    task automatic step(input bit le, input bit ack, input bit lc, input bit iv,
                        input logic [FLIT_W-1:0] f);
        link_en = le; txlinkactiveack = ack; tx_lcrdv = lc; in_valid = iv; in_flit = f;
        model_edge(le, ack, lc, iv, f);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        link_en = 0; txlinkactiveack = 0; tx_lcrdv = 0; in_valid = 0; in_flit = '0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    task automatic bring_up();
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        step(1, 1, 0, 0, '0);
    endtask

    typedef struct {
        bit le, ack, lc, iv;
        int st;
        bit fv, rdy;
        int tag;
    } vec_t;

    vec_t              vt[12];
    logic [FLIT_W-1:0] got[$];
    int                n;
    bit                ack_r, le_r;

    initial begin
        vt = '{
            '{1, 0, 0, 0, 1, 0, 1, 0},
            '{1, 0, 0, 0, 1, 0, 1, 0},
            '{1, 1, 0, 0, 2, 0, 1, 0},
            '{1, 1, 0, 1, 2, 0, 1, 0},
            '{1, 1, 0, 1, 2, 0, 1, 0},
            '{1, 1, 0, 1, 2, 0, 1, 0},
            '{1, 1, 0, 0, 2, 0, 1, 0},
            '{1, 1, 1, 0, 2, 0, 1, 0},
            '{1, 1, 1, 0, 2, 1, 1, 103},
            '{1, 1, 0, 0, 2, 1, 1, 104},
            '{1, 1, 0, 0, 2, 0, 1, 0},
            '{1, 1, 0, 0, 2, 0, 1, 0}
        };
        rst_n = 1'b1;
        link_en = 0; txlinkactiveack = 0; tx_lcrdv = 0; in_valid = 0; in_flit = '0;
        #2;

        // Bring-up and credit gating from the vector table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(vt[i].le, vt[i].ack, vt[i].lc, vt[i].iv, vt[i].iv ? FLIT_W'(i + 100) : '0);
            chk($sformatf("vec%0d state", i), FLIT_W'(link_state), FLIT_W'(vt[i].st));
            chk($sformatf("vec%0d flitv", i), FLIT_W'(tx_flitv), FLIT_W'(vt[i].fv));
            chk($sformatf("vec%0d ready", i), FLIT_W'(in_ready), FLIT_W'(vt[i].rdy));
            if (vt[i].fv) chk($sformatf("vec%0d flit", i), tx_flit, FLIT_W'(vt[i].tag));
        end

        // Back-pressure with DEPTH entries and no credits
        do_reset();
        bring_up();
        for (int k = 0; k < 4; k++) step(1, 1, 0, 1, FLIT_W'(200 + k));
        chk("bp ready after 4th", FLIT_W'(in_ready), '0);
        step(1, 1, 0, 1, FLIT_W'(204));
        chk("bp 5th refused", FLIT_W'(in_ready), '0);
        step(1, 1, 1, 1, FLIT_W'(204));
        step(1, 1, 0, 1, FLIT_W'(204));
        chk("bp first out", FLIT_W'(tx_flitv), FLIT_W'(1));
        chk("bp first flit", tx_flit, FLIT_W'(200));
        chk("bp ready again", FLIT_W'(in_ready), FLIT_W'(1));
        step(1, 1, 0, 1, FLIT_W'(204));
        chk("bp 5th accepted", FLIT_W'(in_ready), '0);
        got.delete();
        for (int k = 0; k < 6; k++) begin
            step(1, 1, (k < 4), 0, '0);
            if (tx_flitv) got.push_back(tx_flit);
        end
        chk("bp drained count", FLIT_W'(got.size()), FLIT_W'(4));
        for (int k = 0; k < got.size(); k++) chk($sformatf("bp order %0d", k), got[k], FLIT_W'(201 + k));

        // Deactivation returns held credits as zero flits
        do_reset();
        bring_up();
        repeat (3) step(1, 1, 1, 0, '0);
        step(0, 1, 0, 0, '0);
        chk("deact state", FLIT_W'(link_state), FLIT_W'(3));
        chk("deact req low", FLIT_W'(txlinkactivereq), '0);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, '0);
            if (tx_flitv && tx_flit == '0) n++;
        end
        chk("deact returns", FLIT_W'(n), FLIT_W'(3));
        step(0, 1, 0, 0, '0);
        chk("deact no 4th", FLIT_W'(tx_flitv), '0);
        chk("deact hold", FLIT_W'(link_state), FLIT_W'(3));
        step(0, 0, 0, 0, '0);
        chk("deact to stop", FLIT_W'(link_state), '0);

        // Credit overflow; the count saturates at MAX_CRD
        do_reset();
        bring_up();
        repeat (MAX_CRD) step(1, 1, 1, 0, '0);
        chk("ovf clear at max", FLIT_W'(crd_ovf), '0);
        step(1, 1, 1, 0, '0);
        chk("ovf set", FLIT_W'(crd_ovf), FLIT_W'(1));
        n = 0;
        for (int k = 0; k < MAX_CRD + 3; k++) begin
            step(0, 0, 0, 0, '0);
            if (tx_flitv) n++;
        end
        chk("ovf returns", FLIT_W'(n), FLIT_W'(MAX_CRD));
        chk("ovf stop", FLIT_W'(link_state), '0);
        chk("ovf sticky", FLIT_W'(crd_ovf), FLIT_W'(1));

        // Credit in and flit out together at count 5; also minimum latency
        do_reset();
        bring_up();
        repeat (5) step(1, 1, 1, 0, '0);
        step(1, 1, 0, 1, FLIT_W'(77));
        chk("lat n+1", FLIT_W'(tx_flitv), '0);
        step(1, 1, 1, 0, '0);
        chk("lat n+2", FLIT_W'(tx_flitv), FLIT_W'(1));
        chk("lat flit", tx_flit, FLIT_W'(77));
        n = 0;
        for (int k = 0; k < 9; k++) begin
            step(0, 0, 0, 0, '0);
            if (tx_flitv) n++;
        end
        chk("simul returns", FLIT_W'(n), FLIT_W'(5));

        // Reset in the middle of RUN with queued flits
        do_reset();
        bring_up();
        step(1, 1, 0, 1, FLIT_W'(55));
        step(1, 1, 0, 1, FLIT_W'(56));
        rst_n = 1'b0;
        #1;
        chk("mid rst state", FLIT_W'(link_state), '0);
        chk("mid rst req", FLIT_W'(txlinkactivereq), '0);
        chk("mid rst flit", tx_flit, '0);
        chk("mid rst ready", FLIT_W'(in_ready), '0);
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 0;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, '0);
            n += int'(tx_flitv);
        end
        bring_up();
        n += int'(tx_flitv);
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 1, 0, '0);
            n += int'(tx_flitv);
        end
        chk("mid rst no flits", FLIT_W'(n), '0);

        // Randomised traffic against the reference model
        do_reset();
        le_r = 0;
        ack_r = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) le_r = !le_r;
            if ($urandom_range(0, 1) == 1) ack_r = m_req;
            step(le_r, ack_r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), rand_flit());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
